// File: rtl/bt_pkt_pkg.sv
// Packet definitions shared by the Bluetooth transmitter and receiver:
// sync byte, packet length, record layout and checksum.
package bt_pkt_pkg;

  localparam logic [7:0]  HEADER  = 8'hA5;
  localparam int unsigned PKT_LEN = 5;
  localparam int unsigned IDX_W   = 3;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] btn;
  } bt_rec_t;

  // Checksum byte: 8-bit sum of the record, carry dropped
  function automatic logic [7:0] chk(input logic [7:0] x, input logic [7:0] y,
                                     input logic [7:0] btn);
    return 8'(x + y + btn);
  endfunction

endpackage

// File: rtl/bt_packet_tx_if.sv
// Record handshake and line outputs of the Bluetooth packet transmitter.
interface bt_packet_tx_if;

  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] btn;
  logic       send;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output x, y, btn, send,
    input  ready, tx, busy, tx_done
  );

  modport slave (
    input  x, y, btn, send,
    output ready, tx, busy, tx_done
  );

endinterface

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser, LSB first, registered line output.
// A byte offered during the last stop-bit cycle starts with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state,    state_nxt;
  logic [7:0]       shreg,    shreg_nxt;
  logic [2:0]       bit_cnt,  bit_cnt_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic             tx_nxt;
  logic             wrap_c;

  assign wrap_c     = (baud_cnt == CNT_LAST);
  assign byte_done  = (state == S_STOP) && wrap_c;
  assign byte_ready = (state == S_IDLE) || byte_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      baud_cnt <= baud_nxt;
      tx       <= tx_nxt;
    end
  end

  // tx_nxt is the line level for the coming cycle, so tx is always a flop
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    baud_nxt    = wrap_c ? '0 : baud_cnt + CNT_W'(1);
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        if (byte_valid) begin
          shreg_nxt = byte_data;
          state_nxt = S_START;
          tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (wrap_c) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      S_DATA: begin
        if (wrap_c) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = {1'b0, shreg[7:1]};
            tx_nxt      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (wrap_c) begin
          if (byte_valid) begin
            shreg_nxt = byte_data;
            state_nxt = S_START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bt_packet_tx.sv
// Bluetooth packet transmitter: latches an (x, y, btn) record and sends
// HEADER, x, y, btn, CHK back to back as UART 8N1 bytes.
module bt_packet_tx
  import bt_pkt_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 125_000_000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter logic [7:0]  HEADER       = bt_pkt_pkg::HEADER
) (
  input  logic           clk,
  input  logic           reset,
  bt_packet_tx_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(PKT_LEN);

  logic [1:0]       state,     state_nxt;
  bt_rec_t          rec,       rec_nxt;
  logic [7:0]       chk_q,     chk_nxt;
  logic [IDX_W-1:0] idx,       idx_nxt;
  logic             ready_q,   ready_nxt;
  logic             busy_q,    busy_nxt;
  logic             tx_done_q, tx_done_nxt;

  logic             accept_c;
  logic             byte_valid_c;
  logic [7:0]       byte_data_c;
  logic             byte_ready;
  logic             byte_done;
  logic             tx_line;

  assign accept_c     = bus.send && ready_q;
  assign byte_valid_c = (state == S_SEND) && (idx != IDX_END);

  // Byte mux in wire order
  always_comb begin
    case (idx)
      IDX_W'(0): byte_data_c = HEADER;
      IDX_W'(1): byte_data_c = rec.x;
      IDX_W'(2): byte_data_c = rec.y;
      IDX_W'(3): byte_data_c = rec.btn;
      default:   byte_data_c = chk_q;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid_c),
    .byte_data  (byte_data_c),
    .byte_ready (byte_ready),
    .byte_done  (byte_done),
    .tx         (tx_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rec       <= '0;
      chk_q     <= '0;
      idx       <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rec       <= rec_nxt;
      chk_q     <= chk_nxt;
      idx       <= idx_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
      tx_done_q <= tx_done_nxt;
    end
  end

  // Packet sequencer; DONE is ready so a held send restarts after one idle cycle
  always_comb begin
    state_nxt   = state;
    rec_nxt     = rec;
    chk_nxt     = chk_q;
    idx_nxt     = idx;
    ready_nxt   = ready_q;
    busy_nxt    = busy_q;
    tx_done_nxt = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept_c) begin
          rec_nxt   = '{x: bus.x, y: bus.y, btn: bus.btn};
          chk_nxt   = chk(bus.x, bus.y, bus.btn);
          idx_nxt   = '0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (byte_valid_c && byte_ready) begin
          idx_nxt = idx + IDX_W'(1);
        end
        if ((idx == IDX_END) && byte_done) begin
          state_nxt   = S_DONE;
          tx_done_nxt = 1'b1;
          busy_nxt    = 1'b0;
          ready_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = tx_done_q;
  assign bus.tx      = tx_line;

endmodule

// File: tb/tb_bt_packet_tx.sv
// Directed bench for bt_packet_tx with a mid-bit sampling UART monitor.
module tb_bt_packet_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bt_packet_tx_if bus();

  bt_packet_tx #(
    .CLK_FREQ     (125_000_000),
    .BAUD         (9600),
    .CLKS_PER_BIT (CPB),
    .HEADER       (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Line monitor: detect start bit, sample each bit in its middle
  int         neg_cyc   = 0;
  int         done_cnt  = 0;
  int         frame_err = 0;
  bit         mon_act   = 1'b0;
  int         mon_ph    = 0;
  int         mon_t0    = 0;
  logic [7:0] mon_sr    = 8'h00;
  logic [7:0] mon_q[$];
  int         mon_t[$];

  always @(negedge clk) begin
    neg_cyc++;
    if (bus.tx_done === 1'b1) done_cnt++;
    if (reset === 1'b1) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (bus.tx === 1'b0) begin
        mon_act = 1'b1;
        mon_ph  = 0;
        mon_t0  = neg_cyc;
      end
    end else begin
      mon_ph++;
      if (mon_ph == CPB / 2 && bus.tx !== 1'b0) frame_err++;
      if (mon_ph >= CPB + CPB / 2 && mon_ph <= 8 * CPB + CPB / 2 && (mon_ph % CPB) == CPB / 2)
        mon_sr = {bus.tx, mon_sr[7:1]};
      if (mon_ph == 9 * CPB + CPB / 2) begin
        if (bus.tx !== 1'b1) frame_err++;
        mon_q.push_back(mon_sr);
        mon_t.push_back(mon_t0);
        mon_act = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_q.delete();
    mon_t.delete();
  endtask

  // Returns at accept edge + 1; acc is the monitor cycle count at that point
  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b,
                          output int acc);
    @(negedge clk);
    bus.x    = x;
    bus.y    = y;
    bus.btn  = b;
    bus.send = 1'b1;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    acc = neg_cyc;
  endtask

  task automatic wait_tx_done(output int lat);
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.tx_done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.send = 1'b0;
    bus.x    = 8'h00;
    bus.y    = 8'h00;
    bus.btn  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL reset_tx_done got=%b exp=0", bus.tx_done); end
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    clear_mon();
  endtask

  task automatic test_basic();
    int acc, lat, d0;
    logic [7:0] exp_b[5];
    exp_b = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h47};
    clear_mon();
    d0 = done_cnt;
    send_pkt(8'h12, 8'h34, 8'h01, acc);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL basic_ready_low got=%b exp=0", bus.ready); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_high got=%b exp=1", bus.busy); end
    wait_tx_done(lat);
    checks++; if (lat !== 201) begin failures++; $display("FAIL basic_done_latency got=%0d exp=201", lat); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back got=%b exp=1", bus.ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_low got=%b exp=0", bus.busy); end
    tick(5);
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (mon_q.size() !== 5) begin failures++; $display("FAIL basic_byte_count got=%0d exp=5", mon_q.size()); end
    if (mon_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (mon_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL basic_byte%0d got=%h exp=%h", i, mon_q[i], exp_b[i]);
        end
      end
      checks++; if (mon_t[0] - acc !== 2) begin failures++; $display("FAIL basic_start_latency got=%0d exp=2", mon_t[0] - acc); end
      checks++; if (mon_t[4] - mon_t[0] !== 160) begin failures++; $display("FAIL basic_byte_spacing got=%0d exp=160", mon_t[4] - mon_t[0]); end
    end
  endtask

  task automatic test_checksum_wrap();
    int acc, lat;
    logic [7:0] xs[2], ys[2], bs[2], cs[2];
    xs = '{8'hFF, 8'h80};
    ys = '{8'h02, 8'h80};
    bs = '{8'h00, 8'h80};
    cs = '{8'h01, 8'h80};
    for (int v = 0; v < 2; v++) begin
      clear_mon();
      send_pkt(xs[v], ys[v], bs[v], acc);
      wait_tx_done(lat);
      tick(5);
      checks++; if (lat !== 201) begin failures++; $display("FAIL chk%0d_latency got=%0d exp=201", v, lat); end
      checks++; if (mon_q.size() !== 5) begin failures++; $display("FAIL chk%0d_byte_count got=%0d exp=5", v, mon_q.size()); end
      if (mon_q.size() == 5) begin
        checks++; if (mon_q[0] !== 8'hA5) begin failures++; $display("FAIL chk%0d_header got=%h exp=a5", v, mon_q[0]); end
        checks++; if (mon_q[1] !== xs[v]) begin failures++; $display("FAIL chk%0d_x got=%h exp=%h", v, mon_q[1], xs[v]); end
        checks++; if (mon_q[4] !== cs[v]) begin failures++; $display("FAIL chk%0d_sum got=%h exp=%h", v, mon_q[4], cs[v]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, d0;
    logic [7:0] exp_b[15];
    exp_b = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h60,
              8'hA5, 8'h55, 8'h20, 8'h30, 8'hA5,
              8'hA5, 8'h77, 8'h20, 8'h30, 8'hC7};
    clear_mon();
    d0 = done_cnt;
    @(negedge clk);
    bus.x    = 8'h10;
    bus.y    = 8'h20;
    bus.btn  = 8'h30;
    bus.send = 1'b1;
    @(posedge clk);
    #1;
    tick(50);
    bus.x = 8'h55;
    wait_tx_done(lat);
    checks++; if (lat !== 152) begin failures++; $display("FAIL b2b_done1 got=%0d exp=152", lat); end
    tick(50);
    bus.x = 8'h77;
    wait_tx_done(lat);
    checks++; if (lat !== 153) begin failures++; $display("FAIL b2b_done2 got=%0d exp=153", lat); end
    wait_tx_done(lat);
    checks++; if (lat !== 202) begin failures++; $display("FAIL b2b_done3 got=%0d exp=202", lat); end
    @(negedge clk);
    bus.send = 1'b0;
    tick(300);
    checks++; if (done_cnt - d0 !== 3) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=3", done_cnt - d0); end
    checks++; if (mon_q.size() !== 15) begin failures++; $display("FAIL b2b_byte_count got=%0d exp=15", mon_q.size()); end
    if (mon_q.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        checks++;
        if (mon_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL b2b_byte%0d got=%h exp=%h", i, mon_q[i], exp_b[i]);
        end
      end
      checks++; if (mon_t[5] - mon_t[0] !== 202) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=202", mon_t[5] - mon_t[0]); end
      checks++; if (mon_t[10] - mon_t[5] !== 202) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=202", mon_t[10] - mon_t[5]); end
    end
  endtask

  task automatic test_reset_mid();
    int acc, lat, d0;
    logic [7:0] exp_b[5];
    exp_b = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h21};
    clear_mon();
    d0 = done_cnt;
    send_pkt(8'h12, 8'h34, 8'h56, acc);
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL abort_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.tx_done !== 1'b0) begin failures++; $display("FAIL abort_tx_done got=%b exp=0", bus.tx_done); end
    reset = 1'b0;
    tick(260);
    checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
    checks++; if (mon_q.size() !== 2) begin failures++; $display("FAIL abort_partial_bytes got=%0d exp=2", mon_q.size()); end
    clear_mon();
    send_pkt(8'h0A, 8'h0B, 8'h0C, acc);
    wait_tx_done(lat);
    tick(5);
    checks++; if (lat !== 201) begin failures++; $display("FAIL after_abort_latency got=%0d exp=201", lat); end
    checks++; if (mon_q.size() !== 5) begin failures++; $display("FAIL after_abort_byte_count got=%0d exp=5", mon_q.size()); end
    if (mon_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (mon_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL after_abort_byte%0d got=%h exp=%h", i, mon_q[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_send_while_busy();
    int acc, d0, first;
    logic [7:0] exp_b[5];
    exp_b = '{8'hA5, 8'h21, 8'h43, 8'h65, 8'hC9};
    clear_mon();
    d0    = done_cnt;
    first = -1;
    send_pkt(8'h21, 8'h43, 8'h65, acc);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (bus.tx_done === 1'b1 && first < 0) first = c;
      bus.send = (c == 10 || c == 100 || c == 199);
      bus.x    = 8'h99;
    end
    bus.send = 1'b0;
    tick(5);
    checks++; if (first !== 201) begin failures++; $display("FAIL busy_done_latency got=%0d exp=201", first); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL busy_done_pulses got=%0d exp=1", done_cnt - d0); end
    checks++; if (mon_q.size() !== 5) begin failures++; $display("FAIL busy_byte_count got=%0d exp=5", mon_q.size()); end
    if (mon_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (mon_q[i] !== exp_b[i]) begin
          failures++;
          $display("FAIL busy_byte%0d got=%h exp=%h", i, mon_q[i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_checksum_wrap();
    test_back_to_back();
    test_reset_mid();
    test_send_while_busy();
    checks++; if (frame_err !== 0) begin failures++; $display("FAIL framing_errors got=%0d exp=0", frame_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
